// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding the architectural HI/LO
// registers. Sits beside the ALU in the execute stage.
//
// Ports:
//   clk    - core clock, all state updates on the rising edge
//   reset  - asynchronous active-high reset, clears all state at once
//   start  - qualifies MDOp for one cycle
//   MDOp   - 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
//   srcA   - multiplicand / dividend / mthi-mtlo value
//   srcB   - multiplier / divisor
//   busy   - high while a multiply/divide is in flight (registered)
//   HI, LO - architectural HI/LO registers (registered)
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [2:0]  op_r;
  logic        busy_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  // {commit, hi, lo}; commit is low for a divide by zero so HI/LO are kept.
  logic [64:0] res_s;

  // Result of an operation on the latched operands.
  function automatic logic [64:0] md_calc(input logic [2:0]  op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sprod;
    logic [63:0] uprod;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q;
    logic [31:0] r;
    // Low 64 bits of the product of sign-extended operands is the signed product.
    sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    uprod = {32'h0000_0000, a} * {32'h0000_0000, b};
    // Signed divide done on magnitudes; 0x80000000 / -1 naturally yields
    // quotient 0x80000000, remainder 0.
    ma = a[31] ? (32'h0000_0000 - a) : a;
    mb = b[31] ? (32'h0000_0000 - b) : b;
    if (mb != 32'h0000_0000) begin
      uq = ma / mb;
      ur = ma % mb;
    end else begin
      uq = 32'h0000_0000;
      ur = 32'h0000_0000;
    end
    q = (a[31] ^ b[31]) ? (32'h0000_0000 - uq) : uq;
    r = a[31] ? (32'h0000_0000 - ur) : ur;
    md_calc = {1'b0, 64'h0};
    case (op)
      3'd0: md_calc = {1'b1, sprod};
      3'd1: md_calc = {1'b1, uprod};
      3'd2: begin
        if (b != 32'h0000_0000) begin
          md_calc = {1'b1, r, q};
        end else begin
          md_calc = {1'b0, 64'h0};
        end
      end
      3'd3: begin
        if (b != 32'h0000_0000) begin
          md_calc = {1'b1, a % b, a / b};
        end else begin
          md_calc = {1'b0, 64'h0};
        end
      end
      default: md_calc = {1'b0, 64'h0};
    endcase
  endfunction

  // Completion result from the latched operands.
  always_comb begin
    res_s = md_calc(op_r, a_r, b_r);
  end

  // Control FSM, operand latches and the architectural HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      a_r     <= 32'h0000_0000;
      b_r     <= 32'h0000_0000;
      op_r    <= 3'd0;
      busy_r  <= 1'b0;
      hi_r    <= 32'h0000_0000;
      lo_r    <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            case (MDOp)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                a_r     <= srcA;
                b_r     <= srcB;
                op_r    <= MDOp;
                cnt_r   <= MDOp[1] ? DIV_CNT : MULT_CNT;
                busy_r  <= 1'b1;
                state_r <= RUN;
              end
              3'd4:    hi_r <= srcA;
              3'd5:    lo_r <= srcA;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt_r <= cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            if (res_s[64]) begin
              hi_r <= res_s[63:32];
              lo_r <= res_s[31:0];
            end
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit with a result
// scoreboard. Expected HI/LO pairs are pushed when an operation is issued and
// popped when busy falls (or after the single edge of mthi/mtlo).
module tb_md_unit;

  localparam int MULT_L = 5;
  localparam int DIV_L  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  MDOp;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sbq[$];
  int          checks;
  int          errors;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_unit #(.MULT_CYCLES(MULT_L), .DIV_CYCLES(DIV_L)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDOp  (MDOp),
    .srcA  (srcA),
    .srcB  (srcB),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop the scoreboard and compare against HI/LO.
  task automatic sb_check(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_hi"}, HI, e.hi);
      chk({tag, "_lo"}, LO, e.lo);
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  // Issue a mult/div at the current negedge and wait for busy to fall.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] eh, input logic [31:0] el,
                        input bit disturb);
    exp_t e;
    int   cycles;
    e.hi = eh;
    e.lo = el;
    sbq.push_back(e);
    start = 1'b1;
    MDOp  = op;
    srcA  = a;
    srcB  = b;
    cycles = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      cycles++;
      chk({tag, "_hold_hi"}, HI, m_hi);
      chk({tag, "_hold_lo"}, LO, m_lo);
      if (cycles == 1) begin
        start = 1'b0;
        srcA  = ~a;
        srcB  = b + 32'd17;
      end
      if (disturb && cycles == 2) begin
        start = 1'b1;
        MDOp  = 3'd5;
        srcA  = 32'h0000_AAAA;
      end
      if (disturb && cycles == 3) begin
        start = 1'b0;
        srcA  = 32'h1357_9BDF;
      end
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(cycles), 32'(lat));
    sb_check(tag);
  endtask

  // mthi (op 4) / mtlo (op 5): one edge, busy never rises.
  task automatic mt_op(input string tag, input logic [2:0] op, input logic [31:0] v);
    exp_t e;
    e.hi = (op == 3'd4) ? v : m_hi;
    e.lo = (op == 3'd5) ? v : m_lo;
    sbq.push_back(e);
    start = 1'b1;
    MDOp  = op;
    srcA  = v;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    sb_check(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_hi   = 32'h0;
    m_lo   = 32'h0;
    reset  = 1'b1;
    start  = 1'b0;
    MDOp   = 3'd0;
    srcA   = 32'h0;
    srcB   = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mult_m3x5", 3'd0, 32'hFFFF_FFFD, 32'd5, MULT_L, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("multu_ffx2", 3'd1, 32'hFFFF_FFFF, 32'd2, MULT_L, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_op("mult_min_sq", 3'd0, 32'h8000_0000, 32'h8000_0000, MULT_L, 32'h4000_0000, 32'h0, 1'b0);
    run_op("mult_m1m1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_L, 32'h0, 32'h1, 1'b0);
    run_op("multu_m1m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_L, 32'hFFFF_FFFE, 32'h1, 1'b0);
    run_op("div_m7d2", 3'd2, 32'hFFFF_FFF9, 32'd2, DIV_L, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_7dm2", 3'd2, 32'd7, 32'hFFFF_FFFE, DIV_L, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_L, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu_7d2", 3'd3, 32'd7, 32'd2, DIV_L, 32'd1, 32'd3, 1'b0);
    run_op("divu_big", 3'd3, 32'hFFFF_FFF9, 32'd2, DIV_L, 32'd1, 32'h7FFF_FFFC, 1'b0);

    // No-op codes leave everything alone.
    start = 1'b1;
    MDOp  = 3'd6;
    srcA  = 32'hDEAD_BEEF;
    @(negedge clk);
    MDOp  = 3'd7;
    @(negedge clk);
    start = 1'b0;
    chk("noop_busy", 32'(busy), 32'd0);
    chk("noop_hi", HI, m_hi);
    chk("noop_lo", LO, m_lo);

    // Divide by zero after a fresh reset and mthi: HI/LO untouched.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'h0;
    m_lo = 32'h0;
    mt_op("mthi", 3'd4, 32'h1234_5678);
    run_op("div_by0", 3'd2, 32'd99, 32'd0, DIV_L, 32'h1234_5678, 32'h0, 1'b0);
    run_op("divu_by0", 3'd3, 32'd99, 32'd0, DIV_L, 32'h1234_5678, 32'h0, 1'b0);
    mt_op("mtlo", 3'd5, 32'h0BAD_F00D);

    // mtlo and srcA change during a mult are ignored.
    run_op("mult_disturb", 3'd0, 32'd1000, 32'd3000, MULT_L, 32'h0, 32'd3000000, 1'b1);
    chk("disturb_no_late_mtlo", LO, 32'd3000000);

    // Asynchronous reset in the middle of a divide.
    mt_op("mthi2", 3'd4, 32'h0000_0011);
    mt_op("mtlo2", 3'd5, 32'h0000_0022);
    start = 1'b1;
    MDOp  = 3'd2;
    srcA  = 32'd100;
    srcB  = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", HI, 32'h0);
    chk("abort_lo", LO, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_late_busy", 32'(busy), 32'd0);
    chk("abort_late_hi", HI, 32'h0);
    chk("abort_late_lo", LO, 32'h0);
    m_hi = 32'h0;
    m_lo = 32'h0;

    // Unit works normally after the abort.
    run_op("post_abort_divu", 3'd3, 32'd100, 32'd7, DIV_L, 32'd2, 32'd14, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
